// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the framed UART command controller.
// Used by uart_cmd_buf and uart_cmd_ctrl.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_WRITE
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_LEN  = 3'd1,
        ERR_BAD_CSUM = 3'd2,
        ERR_TIMEOUT  = 3'd3,
        ERR_OVERRUN  = 3'd4
    } err_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Index width that stays legal for a depth of 1.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [idx_width(MAX_LEN)-1:0]     wr_idx,
    input  logic [7:0]                        wr_data,
    input  logic [idx_width(MAX_LEN)-1:0]     rd_idx,
    output logic [7:0]                        rd_data
);

    logic [7:0] mem [MAX_LEN];

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    // NOTE: the array has no reset; each byte is written in PAYLOAD before WRITE reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_idx) < MAX_LEN) ? mem[rd_idx] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed command controller: sync/ADDR/LEN/payload/CSUM parser replaying validated writes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int unsigned IDX_W = idx_width(MAX_LEN);

    state_t           state, state_nxt;
    logic [7:0]       base_addr, frame_len, csum_acc;
    logic [IDX_W-1:0] idx, rd_idx;
    logic [7:0]       rd_data;
    logic             overrun;
    logic             at_last, handshake, len_bad, timeout_hit, buf_we;
    logic             ok_evt;
    err_t             err_evt;

    // idx doubles as payload write pointer and write-beat counter.
    assign at_last   = (8'(idx) == frame_len - 8'd1);
    assign handshake = wr_en && wr_ready;
    assign len_bad   = (rx_data == 8'd0) || (32'(rx_data) > MAX_LEN);
    assign buf_we    = (state == ST_PAYLOAD) && rx_valid;
    assign rd_idx    = (state == ST_WRITE) ? idx + IDX_W'(1) : '0;

    uart_cmd_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (idx),
        .wr_data (rx_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = idx_width(TIMEOUT_CLKS);
    logic [TO_W-1:0] idle_cnt;
    logic            parsing;

    assign parsing     = state inside {ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CSUM};
    assign timeout_hit = parsing && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (rx_valid || (state_nxt != state) || !parsing) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ST_ADDR;
            ST_ADDR:    if (rx_valid) state_nxt = ST_LEN;
            ST_LEN:     if (rx_valid) state_nxt = len_bad ? ST_IDLE : ST_PAYLOAD;
            ST_PAYLOAD: if (rx_valid && at_last) state_nxt = ST_CSUM;
            ST_CSUM:    if (rx_valid) state_nxt = (rx_data == csum_acc) ? ST_WRITE : ST_IDLE;
            ST_WRITE:   if (handshake && at_last) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) state_nxt = ST_IDLE;
    end

    always_comb begin
        ok_evt  = 1'b0;
        err_evt = ERR_NONE;
        case (state)
            ST_LEN:   if (rx_valid && len_bad) err_evt = ERR_BAD_LEN;
            ST_CSUM:  if (rx_valid && rx_data != csum_acc) err_evt = ERR_BAD_CSUM;
            ST_WRITE: begin
                if (handshake && at_last) begin
                    if (overrun || rx_valid) err_evt = ERR_OVERRUN;
                    else                     ok_evt  = 1'b1;
                end
            end
            default: ;
        endcase
        if (timeout_hit) err_evt = ERR_TIMEOUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr <= 8'h00;
            frame_len <= 8'h00;
            csum_acc  <= 8'h00;
            idx       <= '0;
            overrun   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            frame_ok  <= ok_evt;
            frame_err <= (err_evt != ERR_NONE);
            if (err_evt != ERR_NONE) err_code <= err_evt;
            busy <= (state_nxt != ST_IDLE);

            if (state_nxt == ST_IDLE)             overrun <= 1'b0;
            else if (state == ST_WRITE && rx_valid) overrun <= 1'b1;

            case (state)
                ST_ADDR: begin
                    if (rx_valid) begin
                        base_addr <= rx_data;
                        csum_acc  <= rx_data;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        frame_len <= rx_data;
                        csum_acc  <= csum_acc ^ rx_data;
                        idx       <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        csum_acc <= csum_acc ^ rx_data;
                        if (!at_last) idx <= idx + IDX_W'(1);
                    end
                end
                ST_CSUM: begin
                    if (rx_valid && rx_data == csum_acc) begin
                        idx     <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= base_addr;
                        wr_data <= rd_data;
                    end
                end
                ST_WRITE: begin
                    // Address and data only move on a handshake, so they hold under backpressure.
                    if (handshake) begin
                        if (at_last) begin
                            wr_en <= 1'b0;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            wr_addr <= base_addr + 8'(idx) + 8'd1;
                            wr_data <= rd_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Framed-command controller sitting behind `uart_rx`. It consumes the one-cycle byte strobes `uart_rx` produces, hunts for a sync byte, parses an address/length/payload/checksum frame and buffers the payload. Only after the checksum validates does it replay the payload as a sequence of handshaked register writes. It replaces the direct byte-to-LED path with a controlled, validated write port for the design's register space.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum payload bytes per frame (1..255).
- `TIMEOUT_CLKS`, default 50000: inter-byte idle limit, in clocks, inside a frame.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle byte strobe from `uart_rx`.
- `wr_en`  out  1  write request; held until accepted.
- `wr_addr`  out  8  write address.
- `wr_data`  out  8  write data.
- `wr_ready`  in  1  sink accepts on `wr_en && wr_ready`.
- `busy`  out  1  high in every state except IDLE.
- `frame_ok`  out  1  one-cycle pulse when a frame's writes complete.
- `frame_err`  out  1  one-cycle pulse on a frame error.
- `err_code`  out  3  last error. Held until the next `frame_err`.

## Operation
- Frame format: `0xA5`, ADDR, LEN, LEN payload bytes, CSUM.
  - CSUM is the 8-bit XOR of ADDR, LEN and all payload bytes.
- State machine:
  - IDLE: a byte of `0xA5` → ADDR. All other bytes are discarded silently.
  - ADDR: latch base address; checksum accumulator := byte → LEN.
  - LEN: byte=0 or byte>`MAX_LEN` → error BAD_LEN, → IDLE. Otherwise latch LEN, XOR it into the accumulator, index:=0 → PAYLOAD.
  - PAYLOAD: write the byte to buffer[index] and XOR it into the accumulator. → CSUM after the LEN-th byte. A `0xA5` here is ordinary data.
  - CSUM: byte ≠ accumulator → BAD_CSUM, → IDLE. Otherwise index:=0 → WRITE.
  - WRITE: drive `wr_en`=1, `wr_addr`=(base+index) mod 256, `wr_data`=buffer[index]. Index advances on each handshake.
    - After the LEN-th handshake → IDLE with a pulse: `frame_ok`, or `frame_err`/OVERRUN if the overrun flag is set.
- Error codes: 0 NONE, 1 BAD_LEN, 2 BAD_CSUM, 3 TIMEOUT, 4 OVERRUN.
- Overrun: `rx_valid` in WRITE drops the byte and sets an overrun flag.
  - The validated writes still complete.
  - The flag clears on entry to IDLE.
- Timeout: counter active only in ADDR/LEN/PAYLOAD/CSUM. It clears on every `rx_valid` and on state entry.
  - Reaching `TIMEOUT_CLKS`-1 → TIMEOUT, → IDLE, no writes.
  - `rx_valid` in the same cycle takes priority over timeout.
- No `wr_en` is ever issued for a frame that fails BAD_LEN, BAD_CSUM or TIMEOUT.

## Timing
- Reset values (asynchronous on `rst_n` low, including mid-frame or mid-WRITE):
  - state IDLE.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0.
  - Buffer contents are don't-care.
- All outputs are registered. A state change occurs on the clock edge that samples `rx_valid`.
- Write start: the first `wr_en` is asserted in the cycle after CSUM is accepted.
- Write beats:
  - With `wr_ready` tied high, one write per cycle; LEN writes take LEN cycles.
  - `wr_addr`/`wr_data` must stay stable while `wr_en && !wr_ready`.
- `frame_ok`/`frame_err` pulse in the cycle after the last handshake or error detection. `err_code` updates in the same cycle as its `frame_err`.
- `busy` rises the cycle after the sync byte is accepted and falls with the return to IDLE.

## Configuration
- `UART_CMD_TIMEOUT_EN`:
  - Defined: inter-byte timeout counter and TIMEOUT error present.
  - Undefined: no counter; a frame waits indefinitely; `TIMEOUT_CLKS` unused; code 3 never produced.

## Structure
- `uart_cmd_pkg` holds:
  - the state enum (IDLE, ADDR, LEN, PAYLOAD, CSUM, WRITE);
  - the 3-bit error-code enum;
  - the `SYNC_BYTE`=8'hA5 constant.
- Sub-module `uart_cmd_buf`: `MAX_LEN`×8 payload register file.
  - One write port; combinational read port indexed by the current write index.
  - Addressed by `$clog2(MAX_LEN)`-bit index.

## Test plan
- Good frame: `A5 02 03 11 22 33 01`, `wr_ready`=1 → writes (02,11),(03,22),(04,33) on 3 consecutive cycles, then `frame_ok`, `err_code`=0.
- Bad checksum: `A5 02 03 11 22 33 00` → `frame_err`, `err_code`=2, no `wr_en`; a following good frame is accepted normally.
- Length and noise:
  - `5A 00 A5 05 00` → leading bytes ignored; `frame_err` with BAD_LEN (1).
  - LEN=`MAX_LEN`+1 → BAD_LEN.
- Address wrap with backpressure: `A5 FF 02 AA BB EC`, `wr_ready` low 5 cycles after the first beat → (FF,AA), then (00,BB) held stable until accepted, then `frame_ok`.
- Timeout: `TIMEOUT_CLKS`=100, send `A5 05`, then idle → `frame_err` with TIMEOUT (3) after 100 idle clocks. Bytes arriving at 99 idle clocks must not time out.
- Overrun and reset:
  - `rx_valid` during a stalled WRITE → all writes complete, then `frame_err` OVERRUN (4).
  - `rst_n` pulsed mid-PAYLOAD → all outputs reset, no writes issued.
